// File: rtl/dtlb_refill_queue.sv
// dtlb_refill_queue: de-duplicating dtlb miss queue feeding a single page walker and the dtlb fill port
module dtlb_refill_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 51,
    parameter int DATA_W = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [5:0]             lk_en,
    input  logic [5:0][ADDR_W-1:0] lk_addr,
    input  logic [5:0]             lk_hit,
    output logic [5:0]             replay,
    input  logic                   flush,
    output logic                   walk_req_valid,
    input  logic                   walk_req_ready,
    output logic [ADDR_W-1:0]      walk_req_addr,
    input  logic                   walk_rsp_valid,
    input  logic                   walk_rsp_fault,
    input  logic [DATA_W-1:0]      walk_rsp_data0,
    input  logic [DATA_W-1:0]      walk_rsp_data1,
    input  logic [DATA_W-1:0]      walk_rsp_data2,
    output logic [ADDR_W-1:0]      write_addr,
    output logic [DATA_W-1:0]      write_data0,
    output logic [DATA_W-1:0]      write_data1,
    output logic [DATA_W-1:0]      write_data2,
    output logic                   write_wen,
    output logic                   write_xstant,
    output logic                   write_invl,
    output logic                   busy
);
    localparam int PW = $clog2(DEPTH);
    localparam int KW = ADDR_W - 1;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, WRITE, DRAIN} state_t;

    state_t            state, state_n;
    logic [KW-1:0]     q_key [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [PW:0]       count;
    logic [DEPTH-1:0]  ent_valid;
    logic [5:0]        miss, qmatch, merged;
    logic [2:0]        cand;
    logic              found, push, pop, fault_q;
    logic [KW-1:0]     cand_key, head_key;
    logic [5:0]        unused_lsb;

    assign head_key       = q_key[rd_ptr];
    assign pop            = state == WRITE;
    assign walk_req_valid = state == REQ;
    assign walk_req_addr  = {head_key, 1'b0};
    assign write_wen      = state == WRITE;
    assign write_invl     = write_wen & fault_q;
    assign write_xstant   = 1'b0;
    assign busy           = (count != '0) || (state != IDLE);
    assign unused_lsb     = {lk_addr[5][0], lk_addr[4][0], lk_addr[3][0], lk_addr[2][0], lk_addr[1][0], lk_addr[0][0]};

    // Classify each port's miss as merged, accepted (lowest unmatched one) or replayed
    always_comb begin
        miss   = lk_en & ~lk_hit;
        found  = 1'b0;
        cand   = '0;
        qmatch = '0;
        merged = '0;
        replay = '0;
        for (int i = 0; i < DEPTH; i++)
            ent_valid[i] = {1'b0, PW'(i) - rd_ptr} < count;
        for (int p = 0; p < 6; p++)
            for (int i = 0; i < DEPTH; i++)
                if (ent_valid[i] && q_key[i] == lk_addr[p][ADDR_W-1:1])
                    qmatch[p] = 1'b1;
        for (int p = 0; p < 6; p++)
            if (miss[p] && !qmatch[p] && !found) begin
                found = 1'b1;
                cand  = 3'(p);
            end
        cand_key = lk_addr[cand][ADDR_W-1:1];
        push     = found & ~flush & (~count[PW] | pop);
        for (int p = 0; p < 6; p++) begin
            merged[p] = qmatch[p] | (push && 3'(p) > cand && lk_addr[p][ADDR_W-1:1] == cand_key);
            replay[p] = flush ? miss[p] : miss[p] & ~merged[p] & ~(push && 3'(p) == cand);
        end
    end

    // Queue storage: write the accepted key at the tail
    always_ff @(posedge clk) begin
        if (push)
            q_key[wr_ptr] <= cand_key;
    end

    // Queue pointers and occupancy; flush empties the queue
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= push ? wr_ptr + PW'(1) : wr_ptr;
            rd_ptr <= pop ? rd_ptr + PW'(1) : rd_ptr;
            count  <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        end
    end

    // Walk FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    // Walk FSM next state; a response coinciding with flush in WAIT is dropped
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = (count != '0 && !flush) ? REQ : IDLE;
            REQ:     state_n = flush ? (walk_req_ready ? DRAIN : IDLE) : (walk_req_ready ? WAIT : REQ);
            WAIT:    state_n = walk_rsp_valid ? (flush ? IDLE : WRITE) : (flush ? DRAIN : WAIT);
            WRITE:   state_n = IDLE;
            DRAIN:   state_n = walk_rsp_valid ? IDLE : DRAIN;
            default: state_n = IDLE;
        endcase
    end

    // Capture the walk response and the head address for the fill cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            write_addr  <= '0;
            write_data0 <= '0;
            write_data1 <= '0;
            write_data2 <= '0;
            fault_q     <= 1'b0;
        end else if (state == WAIT && walk_rsp_valid && !flush) begin
            write_addr  <= {head_key, 1'b0};
            write_data0 <= walk_rsp_data0;
            write_data1 <= walk_rsp_data1;
            write_data2 <= walk_rsp_data2;
            fault_q     <= walk_rsp_fault;
        end
    end
endmodule

// File: tb/tb_dtlb_refill_queue.sv
// tb_dtlb_refill_queue: directed and random checks of dtlb_refill_queue against a queue-based model
module tb_dtlb_refill_queue;
    localparam int DEPTH = 4, ADDR_W = 51, DATA_W = 64, KW = ADDR_W - 1;
    localparam int P_IDLE = 0, P_REQ = 1, P_WAIT = 2, P_WR = 3, P_DRAIN = 4;

    logic clk = 0, rst = 0;
    logic [5:0] lk_en, lk_hit, replay;
    logic [5:0][ADDR_W-1:0] lk_addr;
    logic flush, walk_req_valid, walk_req_ready, walk_rsp_valid, walk_rsp_fault;
    logic [ADDR_W-1:0] walk_req_addr, write_addr;
    logic [DATA_W-1:0] walk_rsp_data0, walk_rsp_data1, walk_rsp_data2;
    logic [DATA_W-1:0] write_data0, write_data1, write_data2;
    logic write_wen, write_xstant, write_invl, busy;

    int errs = 0, checks = 0, n;
    logic [KW-1:0] mq[$];
    int ph = P_IDLE, nph;
    logic [DATA_W-1:0] m_d0, m_d1, m_d2;
    logic m_f;
    logic [5:0] m_rep, c_rep;
    logic m_pu, c_pu;
    logic [KW-1:0] m_pk, c_pk;

    dtlb_refill_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .lk_en(lk_en), .lk_addr(lk_addr), .lk_hit(lk_hit), .replay(replay),
        .flush(flush), .walk_req_valid(walk_req_valid), .walk_req_ready(walk_req_ready),
        .walk_req_addr(walk_req_addr), .walk_rsp_valid(walk_rsp_valid), .walk_rsp_fault(walk_rsp_fault),
        .walk_rsp_data0(walk_rsp_data0), .walk_rsp_data1(walk_rsp_data1), .walk_rsp_data2(walk_rsp_data2),
        .write_addr(write_addr), .write_data0(write_data0), .write_data1(write_data1),
        .write_data2(write_data2), .write_wen(write_wen), .write_xstant(write_xstant),
        .write_invl(write_invl), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit in_q(input logic [KW-1:0] k);
        foreach (mq[i]) if (mq[i] == k) return 1'b1;
        return 1'b0;
    endfunction

    // Walk the ports in order: queued/pushed key merges, first new key is pushed if room, rest replay
    function automatic void predict(output logic [5:0] rep, output logic pu, output logic [KW-1:0] pk);
        logic [KW-1:0] k;
        rep = '0; pu = 1'b0; pk = '0;
        for (int p = 0; p < 6; p++) begin
            if (lk_en[p] && !lk_hit[p]) begin
                k = lk_addr[p][ADDR_W-1:1];
                if (flush) rep[p] = 1'b1;
                else if (in_q(k) || (pu && k == pk)) rep[p] = 1'b0;
                else if (!pu && (mq.size() < DEPTH || ph == P_WR)) begin pu = 1'b1; pk = k; end
                else rep[p] = 1'b1;
            end
        end
    endfunction

    // Model update at each clock edge
    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            mq.delete();
            ph = P_IDLE;
        end else begin
            predict(m_rep, m_pu, m_pk);
            nph = ph;
            case (ph)
                P_IDLE:  if (mq.size() > 0 && !flush) nph = P_REQ;
                P_REQ:   if (flush) nph = walk_req_ready ? P_DRAIN : P_IDLE;
                         else if (walk_req_ready) nph = P_WAIT;
                P_WAIT:  if (walk_rsp_valid) begin
                             if (flush) nph = P_IDLE;
                             else begin
                                 nph = P_WR;
                                 m_d0 = walk_rsp_data0; m_d1 = walk_rsp_data1; m_d2 = walk_rsp_data2;
                                 m_f = walk_rsp_fault;
                             end
                         end else if (flush) nph = P_DRAIN;
                P_WR:    nph = P_IDLE;
                P_DRAIN: if (walk_rsp_valid) nph = P_IDLE;
                default: nph = P_IDLE;
            endcase
            if (flush) mq.delete();
            else begin
                if (ph == P_WR) void'(mq.pop_front());
                if (m_pu) mq.push_back(m_pk);
            end
            ph = nph;
        end
    end

    // Compare every output against the model each cycle, away from the clock edge
    initial forever begin
        @(negedge clk);
        #2;
        if (rst) begin
            predict(c_rep, c_pu, c_pk);
            chk("replay", replay, c_rep);
            chk("req_valid", walk_req_valid, ph == P_REQ);
            if (ph == P_REQ) chk("req_addr", walk_req_addr, {mq[0], 1'b0});
            chk("wen", write_wen, ph == P_WR);
            if (ph == P_WR) begin
                chk("wr_addr", write_addr, {mq[0], 1'b0});
                chk("wr_data0", write_data0, m_d0);
                chk("wr_data1", write_data1, m_d1);
                chk("wr_data2", write_data2, m_d2);
                chk("wr_invl", write_invl, m_f);
            end else chk("invl_idle", write_invl, 0);
            chk("xstant", write_xstant, 0);
            chk("busy", busy, mq.size() > 0 || ph != P_IDLE);
        end
    end

    task automatic quiet();
        lk_en = 0; lk_hit = 0; flush = 0; walk_req_ready = 0; walk_rsp_valid = 0; walk_rsp_fault = 0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 0; quiet();
        @(negedge clk); rst = 1;
    endtask

    task automatic rand_walker();
        walk_req_ready = 1'($urandom_range(0, 1));
        walk_rsp_valid = ($urandom_range(0, 3) == 0);
        walk_rsp_fault = 1'($urandom_range(0, 1));
        walk_rsp_data0 = {$urandom, $urandom};
        walk_rsp_data1 = {$urandom, $urandom};
        walk_rsp_data2 = {$urandom, $urandom};
    endtask

    initial begin
        quiet(); lk_addr = '0;
        walk_rsp_data0 = 0; walk_rsp_data1 = 0; walk_rsp_data2 = 0;
        repeat (2) @(negedge clk);
        rst = 1;

        // single miss on port 2, walker answers three cycles after the handshake
        @(negedge clk); lk_en = 6'b000100; lk_addr[2] = 51'h1234; walk_req_ready = 1; #3 chk("t1_replay", replay, 0);
        @(negedge clk); lk_en = 0; #3 chk("t1_busy", busy, 1);
        @(negedge clk); #3 chk("t1_req_valid", walk_req_valid, 1); chk("t1_req_addr", walk_req_addr, 51'h1234);
        @(negedge clk); walk_req_ready = 0;
        @(negedge clk);
        @(negedge clk); walk_rsp_valid = 1;
        walk_rsp_data0 = 64'h1111_2222_3333_4444; walk_rsp_data1 = 64'h5555_6666_7777_8888; walk_rsp_data2 = 64'h9999_aaaa_bbbb_cccc;
        @(negedge clk); walk_rsp_valid = 0;
        #3 chk("t1_wen", write_wen, 1); chk("t1_wr_addr", write_addr, 51'h1234);
        chk("t1_d0", write_data0, 64'h1111_2222_3333_4444); chk("t1_d1", write_data1, 64'h5555_6666_7777_8888);
        chk("t1_d2", write_data2, 64'h9999_aaaa_bbbb_cccc); chk("t1_invl", write_invl, 0);
        @(negedge clk); #3 chk("t1_wen_off", write_wen, 0); chk("t1_busy_off", busy, 0);

        // async reset while waiting on the walker with three entries queued
        @(negedge clk); lk_en = 1; lk_addr[0] = 51'h100;
        @(negedge clk); lk_addr[0] = 51'h200;
        @(negedge clk); lk_addr[0] = 51'h300; walk_req_ready = 1;
        @(negedge clk); lk_en = 0; walk_req_ready = 0;
        #5 rst = 0;
        #1 chk("t6_busy", busy, 0); chk("t6_req_valid", walk_req_valid, 0); chk("t6_wen", write_wen, 0);
        chk("t6_wr_addr", write_addr, 0); chk("t6_d0", write_data0, 0); chk("t6_invl", write_invl, 0);
        @(negedge clk); rst = 1;
        @(negedge clk); walk_rsp_valid = 1;
        @(negedge clk); walk_rsp_valid = 0; #3 chk("t6_late_wen", write_wen, 0); chk("t6_late_busy", busy, 0);

        // same-cycle merge and replay: ports 0,1,3 with keys A,A,B
        do_reset();
        @(negedge clk); lk_en = 6'b001011; lk_addr[0] = 51'h4000; lk_addr[1] = 51'h4001; lk_addr[3] = 51'h8000;
        #3 chk("t2_replay", replay, 6'b001000);
        @(negedge clk); lk_en = 6'b001000; #3 chk("t2_retry", replay, 0);
        @(negedge clk); lk_en = 0; #3 chk("t2_model_count", mq.size(), 2); chk("t2_req_addr", walk_req_addr, 51'h4000);

        // full queue replays, then a push alongside the WRITE pop, then pointer wrap
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); lk_en = 1; lk_addr[0] = ADDR_W'((i + 1) * 64); #3 chk("t3_fill", replay[0], 0);
        end
        @(negedge clk); lk_addr[0] = ADDR_W'(5 * 64); #3 chk("t3_full_replay", replay[0], 1);
        @(negedge clk); lk_en = 0; walk_req_ready = 1;
        @(negedge clk); walk_req_ready = 0; walk_rsp_valid = 1;
        @(negedge clk); walk_rsp_valid = 0; lk_en = 1; lk_addr[0] = ADDR_W'(5 * 64);
        #3 chk("t3_write_cycle", write_wen, 1); chk("t3_push_pop", replay[0], 0);
        n = 5;
        for (int c = 0; c < 2000 && n < 12; c++) begin
            @(negedge clk); lk_en = 1; lk_addr[0] = ADDR_W'((n + 1) * 64); rand_walker();
            #3 if (!replay[0]) n++;
        end
        chk("t3_all_accepted", n, 12);
        @(negedge clk); lk_en = 0;
        for (int w = 0; w < 500 && busy; w++) begin
            @(negedge clk); rand_walker(); #3;
        end
        chk("t3_drained", busy, 0);

        // faulting walk produces an invalidating fill at the head address
        do_reset();
        @(negedge clk); lk_en = 6'b100000; lk_addr[5] = 51'h5679; walk_req_ready = 1;
        @(negedge clk); lk_en = 0;
        @(negedge clk); #3 chk("t4_req_addr", walk_req_addr, 51'h5678);
        @(negedge clk); walk_rsp_valid = 1; walk_rsp_fault = 1;
        @(negedge clk); walk_rsp_valid = 0; walk_rsp_fault = 0;
        #3 chk("t4_wen", write_wen, 1); chk("t4_invl", write_invl, 1); chk("t4_wr_addr", write_addr, 51'h5678);

        // flush while waiting: drain the response, no write, queue empty
        do_reset();
        @(negedge clk); lk_en = 6'b000010; lk_addr[1] = 51'h700;
        @(negedge clk); lk_en = 6'b010000; lk_addr[4] = 51'h800;
        @(negedge clk); lk_en = 0; walk_req_ready = 1;
        @(negedge clk); walk_req_ready = 0; flush = 1;
        @(negedge clk); flush = 0; walk_rsp_valid = 1;
        #3 chk("t5_drain_busy", busy, 1); chk("t5_drain_req", walk_req_valid, 0); chk("t5_drain_wen", write_wen, 0);
        @(negedge clk); walk_rsp_valid = 0; #3 chk("t5_no_wen", write_wen, 0); chk("t5_idle", busy, 0);
        @(negedge clk); #3 chk("t5_no_req", walk_req_valid, 0);

        // random traffic over a small key pool so merges, full queue and flushes all occur
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            lk_en = 6'($urandom);
            lk_hit = 6'($urandom) & 6'($urandom);
            for (int p = 0; p < 6; p++)
                lk_addr[p] = (ADDR_W'($urandom_range(1, 8)) << 44) | ADDR_W'($urandom_range(0, 1));
            flush = ($urandom_range(0, 31) == 0);
            rand_walker();
        end
        @(negedge clk); quiet();
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
